// File: rtl/buffer_stream_sequencer.sv
// rtl/buffer_stream_sequencer.sv - port-B sequencer: streams the input buffer to the core, writes results back
// Owns memory_unit port B for one run; writes win the single port, reads fill a one-byte output stage.
module buffer_stream_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              sel_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic              cs_b_o,
  output logic              we_b_o,
  output logic [7:0]        data_b_o,
  input  logic [7:0]        data_b_i,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   out_count,
  output logic              ovf
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] rd_ptr, wr_ptr;
  logic            rd_pending, wr_done;
  logic            rd_done, run_exit;
  logic            wr_fire, rd_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    sel_o    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    s_ready  = 1'b0;
    cs_b_o   = 1'b0;
    we_b_o   = 1'b0;
    addr_b_o = '0;
    data_b_o = '0;
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    rd_done  = (rd_ptr == DEPTH_C);
    run_exit = rd_done && wr_done && !m_valid && !rd_pending;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        sel_o   = 1'b1;
        busy    = 1'b1;
        s_ready = !wr_done;
        // A result beat always takes the port; a read only fills an empty or draining output stage.
        if (s_valid && !wr_done) begin
          wr_fire  = 1'b1;
          cs_b_o   = 1'b1;
          we_b_o   = 1'b1;
          addr_b_o = wr_ptr[ADDR_W-1:0];
          data_b_o = s_data;
        end else if (!rd_done && !rd_pending && (!m_valid || m_ready)) begin
          rd_fire  = 1'b1;
          cs_b_o   = 1'b1;
          addr_b_o = rd_ptr[ADDR_W-1:0];
        end
        if (run_exit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rd_pending <= 1'b0;
      wr_done    <= 1'b0;
      ovf        <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        rd_pending <= 1'b0;
        wr_done    <= 1'b0;
        ovf        <= 1'b0;
        m_valid    <= 1'b0;
      end
    end else if (state_q == RUN) begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + ONE_C;
        if (s_last || (wr_ptr == LAST_C)) wr_done <= 1'b1;
        if (wr_ptr == LAST_C) ovf <= !s_last;
      end
      if (rd_fire) rd_ptr <= rd_ptr + ONE_C;
      // Read data arrives one cycle after the access; a load always refills the stage.
      if (rd_pending) begin
        m_data  <= data_b_i;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      rd_pending <= rd_fire;
    end
  end

  assign out_count = wr_ptr;

endmodule

// File: tb/tb_buffer_stream_sequencer.sv
// tb/tb_buffer_stream_sequencer.sv - scoreboard bench for buffer_stream_sequencer
module tb_buffer_stream_sequencer;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              sel_o, cs_b_o, we_b_o;
  logic [ADDR_W-1:0] addr_b_o;
  logic [7:0]        data_b_o;
  logic [7:0]        data_b_i;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready, busy, done, ovf;
  logic [ADDR_W:0]   out_count;

  buffer_stream_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_o(sel_o), .addr_b_o(addr_b_o),
    .cs_b_o(cs_b_o), .we_b_o(we_b_o), .data_b_o(data_b_o), .data_b_i(data_b_i),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .s_data(s_data),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready), .busy(busy),
    .done(done), .out_count(out_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [7:0]  in_mem [DEPTH];
  logic [7:0]  res [8];
  logic [7:0]  exp_m [$];
  logic [15:0] exp_wr [$];
  logic [7:0]  rx_q [$];
  logic [15:0] w;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;
  int          tests = 0;
  int          fails = 0;
  int          acc = 0;
  int          rd_seen = 0;
  int          k_exp = 0;
  bit          run_active = 1'b0;

  always @(posedge clk) begin
    if (cs_b_o && !we_b_o) data_b_i <= in_mem[addr_b_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("m_hold_valid", m_valid, 1);
        chk("m_hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        rx_q.push_back(m_data);
        if (exp_m.size() == 0) begin
          tests++; fails++;
          $display("FAIL m_extra_byte: got %0h expected no byte", m_data);
        end else chk("m_byte", m_data, exp_m.pop_front());
      end
      if (s_valid && s_ready) begin
        acc++;
        chk("wr_on_accept", {cs_b_o, we_b_o}, 2'b11);
        chk("accept_within_limit", acc <= k_exp, 1);
      end
      if (cs_b_o && we_b_o) begin
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_extra: got addr %0h data %0h expected no write", addr_b_o, data_b_o);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", addr_b_o, w[15:8]);
          chk("wr_data", data_b_o, w[7:0]);
        end
      end
      if (cs_b_o && !we_b_o) begin
        chk("rd_addr", addr_b_o, rd_seen);
        rd_seen++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic core_drv(input bit echo, input int n_res, input int last_idx, input int sv_pct);
    int idx = 0;
    bit fired = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    while (run_active) begin
      @(posedge clk); #1;
      if (fired) begin
        idx++;
        s_valid = 1'b0;
      end
      if (!s_valid && idx < n_res && (!echo || rx_q.size() > idx) && $urandom_range(99) < sv_pct) begin
        s_valid = 1'b1;
        s_data  = echo ? 8'(rx_q[idx] + 8'd1) : res[idx];
        s_last  = (idx == last_idx);
      end
      @(negedge clk);
      fired = s_valid && s_ready;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic mr_drv(input int pct);
    while (run_active) begin
      @(posedge clk); #1;
      m_ready = ($urandom_range(99) < pct);
    end
    m_ready = 1'b0;
  endtask

  task automatic do_run(input string tag, input bit fixed, input bit echo, input int n_res,
                        input int last_idx, input int mr_pct, input int sv_pct,
                        input bit mid_start, input bit dstart, input int abort_at);
    int k;
    bit eovf;
    bit got;
    for (int i = 0; i < DEPTH; i++) in_mem[i] = fixed ? 8'(11 * (i + 1)) : 8'($urandom);
    for (int i = 0; i < 8; i++) res[i] = 8'($urandom);
    k = n_res;
    if (last_idx >= 0 && last_idx + 1 < k) k = last_idx + 1;
    if (k > DEPTH) k = DEPTH;
    eovf = (k == DEPTH) && (last_idx != DEPTH - 1);
    exp_m.delete(); exp_wr.delete(); rx_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_m.push_back(in_mem[i]);
    for (int i = 0; i < k; i++) exp_wr.push_back({8'(i), echo ? 8'(in_mem[i] + 8'd1) : res[i]});
    acc = 0; rd_seen = 0; k_exp = k;
    run_active = 1'b1;
    fork
      core_drv(echo, n_res, last_idx, sv_pct);
      mr_drv(mr_pct);
    join_none
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_busy_on"}, {busy, sel_o}, 2'b11);
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        start = (mid_start && c == 5);
        if (c == abort_at) begin
          #2 rst = 1'b0;
          #1;
          chk({tag, "_abort_outputs"}, {sel_o, cs_b_o, m_valid, busy, s_ready}, 0);
          run_active = 1'b0; start = 1'b0;
          repeat (3) @(posedge clk);
          #1 rst = 1'b1;
          chk({tag, "_abort_flags"}, {done, ovf, out_count}, 0);
          exp_m.delete(); exp_wr.delete();
          return;
        end
      end
    end
    start = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done in 400 cycles expected done", tag);
      run_active = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
    end else begin
      chk({tag, "_done_sel"}, {sel_o, busy}, 0);
      chk({tag, "_out_count"}, out_count, k);
      chk({tag, "_ovf"}, ovf, eovf);
      chk({tag, "_m_left"}, exp_m.size(), 0);
      chk({tag, "_wr_left"}, exp_wr.size(), 0);
      chk({tag, "_reads"}, rd_seen, DEPTH);
      if (dstart) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, {done, busy, sel_o, s_ready}, 0);
      run_active = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_count_held"}, out_count, k);
      chk({tag, "_ovf_held"}, ovf, eovf);
    end
  endtask

  initial begin
    int n, last;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {sel_o, cs_b_o, busy, done, m_valid, s_ready, ovf}, 0);
    chk("reset_count", out_count, 0);
    rst = 1'b1;
    do_run("echo_basic", 1, 1, 4, 3, 100, 100, 0, 0, -1);
    do_run("echo_ready_toggle", 1, 1, 4, 3, 50, 100, 0, 1, -1);
    do_run("write_burst", 0, 0, 4, 3, 100, 100, 0, 0, -1);
    do_run("early_last", 0, 0, 2, 1, 30, 100, 0, 0, -1);
    do_run("overflow", 0, 0, 5, -1, 70, 100, 1, 0, -1);
    do_run("last_on_full", 0, 0, 4, 3, 60, 60, 0, 0, -1);
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 6);
      last = (n >= DEPTH && $urandom_range(1) == 1) ? -1 : int'($urandom_range(0, n - 1));
      do_run("random", 0, 1'($urandom_range(1)), n, last, $urandom_range(20, 100),
             $urandom_range(20, 100), 1'($urandom_range(1)), 1'($urandom_range(1)), -1);
    end
    do_run("abort", 0, 0, 4, 3, 50, 50, 0, 0, 6);
    do_run("after_abort", 1, 1, 4, 3, 80, 80, 0, 0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
